// File: rtl/bsk_cache_slot_sched.sv
// BSK cache ring scheduler: reserves slots for batch commands, issues fetches to bsk_if,
// tracks fill/consume with wrap-aware pointers and sequences the reset_bsk_cache flush.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal operation, commands accepted while ring not full
// DRAIN    | flush requested; finish the in-flight fetch and wait for fills
// CLEAR    | one cycle: all pointers return to 0
// DONE     | one cycle: reset_cache_done asserted
// WAIT_LOW | hold until reset_cache is released
module bsk_cache_slot_sched #(
    parameter  int SLOT_NB = 4,
    localparam int SLOT_W  = $clog2(SLOT_NB)
) (
    input  logic                clk,
    input  logic                s_rst_n,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    output logic                fetch_vld,
    input  logic                fetch_rdy,
    output logic [SLOT_W-1:0]   fetch_slot,
    input  logic                inc_wr_ptr,
    output logic                batch_start_vld,
    output logic [SLOT_NB-1:0]  batch_start_1h,
    input  logic                inc_rd_ptr,
    input  logic                reset_cache,
    output logic                reset_cache_done,
    output logic [SLOT_W:0]     occupancy,
    output logic                err_wr_ovf,
    output logic                err_rd_udf
);

    localparam int                 PW       = SLOT_W + 1;
    localparam logic [PW-1:0]      PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]      PTR_FULL = PW'(SLOT_NB);
    localparam logic [SLOT_NB-1:0] OH_LSB   = SLOT_NB'(1);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_CLEAR,
        ST_DONE,
        ST_WAIT_LOW
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [PW-1:0]   r_req_ptr;
    logic [PW-1:0]   r_fetch_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            r_fetch_vld;
    logic            r_bs_vld;
    logic            r_err_wr_ovf;
    logic            r_err_rd_udf;
    logic            r_rdy_en;

    logic [PW-1:0]   w_req_nxt;
    logic [PW-1:0]   w_fetch_nxt;
    logic [PW-1:0]   w_wr_nxt;
    logic [PW-1:0]   w_rd_nxt;
    logic            w_fetch_vld_nxt;
    logic            w_bs_vld_nxt;
    logic            w_live;
    logic            w_cmd_acc;
    logic            w_fetch_acc;
    logic            w_wr_ok;
    logic            w_rd_ok;

    assign occupancy  = r_req_ptr - r_rd_ptr;
    assign cmd_rdy    = r_rdy_en && (r_state == ST_RUN) && (occupancy < PTR_FULL);
    assign w_cmd_acc  = cmd_vld && cmd_rdy;
    assign w_fetch_acc = r_fetch_vld && fetch_rdy;

    // Fill and release only make sense while the ring holds live data.
    assign w_live  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_wr_ok = w_live && (r_wr_ptr != r_fetch_ptr);
    assign w_rd_ok = w_live && (r_wr_ptr != r_rd_ptr);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (reset_cache) w_state_nxt = ST_DRAIN;
            ST_DRAIN:    if (!r_fetch_vld && (r_wr_ptr == r_fetch_ptr)) w_state_nxt = ST_CLEAR;
            ST_CLEAR:    w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!reset_cache) w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        w_req_nxt       = r_req_ptr   + (w_cmd_acc   ? PTR_ONE : '0);
        w_fetch_nxt     = r_fetch_ptr + (w_fetch_acc ? PTR_ONE : '0);
        w_wr_nxt        = r_wr_ptr    + ((inc_wr_ptr && w_wr_ok) ? PTR_ONE : '0);
        w_rd_nxt        = r_rd_ptr    + ((inc_rd_ptr && w_rd_ok) ? PTR_ONE : '0);
        w_fetch_vld_nxt = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_req_nxt   = '0;
            w_fetch_nxt = '0;
            w_wr_nxt    = '0;
            w_rd_nxt    = '0;
        end
        // An offered fetch is never withdrawn; new ones issue only in RUN with no flush pending.
        if (r_fetch_vld && !fetch_rdy) begin
            w_fetch_vld_nxt = 1'b1;
        end else if ((r_state == ST_RUN) && !reset_cache) begin
            w_fetch_vld_nxt = (w_req_nxt != w_fetch_nxt);
        end
        w_bs_vld_nxt = ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN))
                       && (w_wr_nxt != w_rd_nxt);
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            r_state      <= ST_RUN;
            r_req_ptr    <= '0;
            r_fetch_ptr  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fetch_vld  <= 1'b0;
            r_bs_vld     <= 1'b0;
            r_err_wr_ovf <= 1'b0;
            r_err_rd_udf <= 1'b0;
            r_rdy_en     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ptr    <= w_req_nxt;
            r_fetch_ptr  <= w_fetch_nxt;
            r_wr_ptr     <= w_wr_nxt;
            r_rd_ptr     <= w_rd_nxt;
            r_fetch_vld  <= w_fetch_vld_nxt;
            r_bs_vld     <= w_bs_vld_nxt;
            r_err_wr_ovf <= inc_wr_ptr && !w_wr_ok;
            r_err_rd_udf <= inc_rd_ptr && !w_rd_ok;
            r_rdy_en     <= 1'b1;
        end
    end

    assign fetch_vld        = r_fetch_vld;
    assign fetch_slot       = r_fetch_ptr[SLOT_W-1:0];
    assign batch_start_vld  = r_bs_vld;
    assign batch_start_1h   = r_bs_vld ? (OH_LSB << r_rd_ptr[SLOT_W-1:0]) : '0;
    assign reset_cache_done = (r_state == ST_DONE);
    assign err_wr_ovf       = r_err_wr_ovf;
    assign err_rd_udf       = r_err_rd_udf;

endmodule

// File: doc/bsk_cache_slot_sched.md
Name: bsk_cache_slot_sched

Overview:
Schedules the BSK cache ring between the BSK fetch engine (bsk_if side) and the PBS NTT/MMACC consumer (pe_pbs side). Each accepted batch command reserves one cache slot and issues a fetch request. The block tracks fill and consumption with wrap-aware pointers, exposes the slot the consumer may start on, and sequences the reset_bsk_cache flush handshake. It sits inside pe_pbs_with_bsk, between the batch command path and bsk_if/bsk_manager.

Parameters:
SLOT_NB, 4, number of BSK cache slots; power of 2, range 2..16.
SLOT_W, $clog2(SLOT_NB), slot index width (derived; not overridable).

Ports:
clk  in  1  process clock
s_rst_n  in  1  synchronous reset, active low
cmd_vld  in  1  batch command valid
cmd_rdy  out  1  batch command accepted when cmd_vld & cmd_rdy
fetch_vld  out  1  fetch request to bsk_if
fetch_rdy  in  1  bsk_if accepts fetch request
fetch_slot  out  SLOT_W  slot to be filled
inc_wr_ptr  in  1  pulse: bsk_if finished filling the oldest pending slot
batch_start_vld  out  1  a filled slot is available to the consumer
batch_start_1h  out  SLOT_NB  one-hot of the slot at rd_ptr; 0 when batch_start_vld=0
inc_rd_ptr  in  1  pulse: consumer releases slot at rd_ptr
reset_cache  in  1  level request: flush cache
reset_cache_done  out  1  one-cycle pulse: flush complete
occupancy  out  SLOT_W+1  reserved slots (req_ptr - rd_ptr)
err_wr_ovf  out  1  pulse: inc_wr_ptr with no fetch outstanding
err_rd_udf  out  1  pulse: inc_rd_ptr with no filled slot

Behaviour:
- Reset values: all pointers 0, FSM=RUN, fetch_vld=0, cmd_rdy=0 for the reset cycle (then 1), batch_start_vld=0, batch_start_1h=0, reset_cache_done=0, occupancy=0, err_*=0.
- Pointers req_ptr, wr_ptr and rd_ptr are SLOT_W+1 bits; the MSB is the wrap bit. Slot index = ptr[SLOT_W-1:0]. Arithmetic is modulo 2^(SLOT_W+1).
- Invariants: rd_ptr <= wr_ptr <= req_ptr (wrap-aware), and req_ptr - rd_ptr <= SLOT_NB.
- Fetch pipe:
  - A fetch is pending iff req_ptr != fetch_ptr.
  - fetch_vld is registered; fetch_slot = fetch_ptr[SLOT_W-1:0].
  - fetch_ptr increments on fetch_vld & fetch_rdy.
  - fetch_vld and fetch_slot hold stable until accepted.
- cmd_rdy = (FSM==RUN) & (occupancy < SLOT_NB). This is combinational from registered state and has no dependence on cmd_vld.
- On cmd accept: req_ptr++. The first fetch_vld appears the next cycle (1-cycle latency).
- inc_wr_ptr: wr_ptr++ if wr_ptr != fetch_ptr (accepted fetch outstanding). Otherwise the pulse is ignored and err_wr_ovf=1 for 1 cycle.
- batch_start_vld = (wr_ptr != rd_ptr), registered.
- batch_start_1h = 1 << rd_ptr[SLOT_W-1:0] when valid.
- inc_rd_ptr: rd_ptr++ if wr_ptr != rd_ptr. Otherwise the pulse is ignored and err_rd_udf=1 for 1 cycle.
- Simultaneous events in one cycle are all applied. Cmd accept, fetch accept, inc_wr_ptr and inc_rd_ptr in the same cycle are all legal. occupancy updates next cycle as (+1 accept) (-1 release).
- When the ring is full, a release and a new cmd in the same cycle still see cmd_rdy=0 that cycle. No bypass.
- FSM states:
  - RUN: on reset_cache=1 go to DRAIN; cmd_rdy forced 0.
  - DRAIN: stop issuing new fetch requests once the current fetch_vld is accepted. fetch_vld is never dropped while unaccepted. Wait until wr_ptr==fetch_ptr (all accepted fetches filled). Then go to CLEAR. The consumer may keep releasing slots.
  - CLEAR: one cycle. Set req_ptr=fetch_ptr=wr_ptr=rd_ptr=0. Discard filled slots and unissued requests. Go to DONE.
  - DONE: reset_cache_done=1 for exactly one cycle. Go to WAIT_LOW.
  - WAIT_LOW: stay until reset_cache=0, then go to RUN. This prevents a retrigger on a held level.
- During CLEAR, DONE and WAIT_LOW: batch_start_vld=0, and inc_rd_ptr/inc_wr_ptr pulses raise the corresponding error pulse.
- s_rst_n low in any state returns everything to reset values on the next edge. No done pulse is generated.

Test Plan:
1. SLOT_NB=4. After reset, 4 back-to-back cmds with fetch_rdy=1 -> fetch_slot 0,1,2,3 on consecutive cycles; cmd_rdy=0 after the 4th accept; occupancy=4.
2. Full ring, then inc_wr_ptr x2 and inc_rd_ptr x1 -> batch_start_1h=4'b0001 then 4'b0010; occupancy=3; cmd_rdy=1 the cycle after the release.
3. Wrap: 10 cmd/fill/release cycles -> fetch_slot sequence 0,1,2,3,0,1,2,3,0,1; pointer MSB toggles at 4 and 8; no error pulses.
4. Same-cycle cmd accept, inc_wr_ptr and inc_rd_ptr at occupancy=2 -> occupancy stays 2; wr_ptr and rd_ptr each advance by 1.
5. reset_cache raised with 2 fetches accepted, 1 unaccepted and fetch_rdy=0 -> fetch_vld holds; after acceptance and 3 inc_wr_ptr, CLEAR; reset_cache_done pulses once; occupancy=0; cmd_rdy stays 0 until reset_cache falls.
6. inc_rd_ptr with empty ring and inc_wr_ptr with no fetch outstanding -> err_rd_udf and err_wr_ovf each pulse 1 cycle; pointers unchanged.
